// File: rtl/uart_transmitter.sv
// UART transmit path: a one-byte holding buffer feeds an 8-data, even-parity,
// 1-stop serializer timed by a 16x oversample enable from baud_controller.

module baud_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] baud_select,
  output logic       sample_enable_c
);

  localparam int unsigned CNT_W = 14;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] limit_c;

  // Terminal counts for a 50 MHz clock at 16x the selected baud rate (300 .. 115200)
  always_comb begin
    limit_c = CNT_W'(10416);
    case (baud_select)
      3'd0: limit_c = CNT_W'(10416);
      3'd1: limit_c = CNT_W'(2603);
      3'd2: limit_c = CNT_W'(650);
      3'd3: limit_c = CNT_W'(325);
      3'd4: limit_c = CNT_W'(162);
      3'd5: limit_c = CNT_W'(80);
      3'd6: limit_c = CNT_W'(53);
      3'd7: limit_c = CNT_W'(26);
    endcase
    // >= lets a rate change mid-count wrap cleanly instead of running to overflow
    sample_enable_c = (cnt_q >= limit_c);
    cnt_d           = sample_enable_c ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

module uart_transmitter #(
  parameter int unsigned TICKS_PER_BIT = 16,
  parameter int unsigned DATA_BITS     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] baud_select,
  input  logic       Tx_EN,
  input  logic       Tx_WR,
  input  logic [7:0] Tx_DATA,
  output logic       TxD,
  output logic       Tx_BUSY,
  output logic       Tx_READY
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned TICK_W = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
  localparam int unsigned BIT_W  = $clog2(DATA_BITS);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e              state_q, state_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [BYTE_W-1:0]   shift_q, shift_d;
  logic                parity_q, parity_d;
  logic [BYTE_W-1:0]   buf_q, buf_d;
  logic                buf_full_q, buf_full_d;
  logic                txd_q, txd_d;
  logic                busy_q, busy_d;
  logic                ready_q, ready_d;
  logic                baud_en_c;
  logic                bit_end_c;
  logic                load_c;
  logic                accept_c;

  baud_controller u_baud (
    .clk             (clk),
    .reset           (reset),
    .baud_select     (baud_select),
    .sample_enable_c (baud_en_c)
  );

  // Next-state, buffer and output decode
  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    load_c     = 1'b0;
    accept_c   = Tx_EN && Tx_WR && !buf_full_q;
    bit_end_c  = baud_en_c && (tick_q == TICK_LAST);

    if (state_q != S_IDLE && baud_en_c) begin
      tick_d = bit_end_c ? '0 : tick_q + TICK_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        load_c = buf_full_q && Tx_EN;
      end
      S_START: begin
        if (bit_end_c) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (bit_end_c) begin
          shift_d = {1'b0, shift_q[BYTE_W-1:1]};
          if (bit_q == BIT_LAST) begin
            state_d = S_PARITY;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      S_PARITY: begin
        if (bit_end_c) begin
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_end_c) begin
          if (buf_full_q && Tx_EN) begin
            load_c = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Load and accept are exclusive: load needs a full buffer, accept an empty one
    if (load_c) begin
      state_d    = S_START;
      tick_d     = '0;
      shift_d    = buf_q;
      parity_d   = ^buf_q;
      buf_full_d = 1'b0;
    end
    if (accept_c) begin
      buf_d      = Tx_DATA;
      buf_full_d = 1'b1;
    end

    case (state_q)
      S_START:  txd_d = 1'b0;
      S_DATA:   txd_d = shift_q[0];
      S_PARITY: txd_d = parity_q;
      default:  txd_d = 1'b1;
    endcase
    busy_d  = (state_d != S_IDLE);
    ready_d = !buf_full_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      tick_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      txd_q      <= txd_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
    end
  end

  assign TxD      = txd_q;
  assign Tx_BUSY  = busy_q;
  assign Tx_READY = ready_q;

endmodule
